cmp_arbiter: RTL

Shares one signed subtract-and-compare datapath between two requesters: the branch unit (port 0) and the set-less-than path (port 1). Each request carries two operands and a 3-bit compare function. The block grants the requesters round-robin, computes A−B with Zero/Overflow/Negative flags, evaluates the condition, and holds a tagged result until the consumer accepts it. It sits between instruction decode and the writeback/PC-select logic in the multi-cycle core.

---
 rtl/cmp_arbiter_if.sv | 31 +++
 rtl/cmp_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/cmp_arbiter_if.sv
// cmp_arbiter_if: bundle for the shared compare unit.
//   req0_* : branch-unit request (valid/ready, a, b, ft)
//   req1_* : set-less-than request (valid/ready, a, b, ft)
//   rsp_*  : tagged result (valid/ready, id, s, zero, neg, ovf, err)
// slave modport is the arbiter side, master is the requester/consumer side.
interface cmp_arbiter_if #(parameter int WIDTH = 32);
  logic             req0_valid, req0_ready;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic [2:0]       req0_ft;
  logic             req1_valid, req1_ready;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [2:0]       req1_ft;
  logic             rsp_valid, rsp_ready;
  logic             rsp_id, rsp_s, rsp_zero, rsp_neg, rsp_ovf, rsp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ft,
    input  req1_valid, req1_a, req1_b, req1_ft,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_s, rsp_zero, rsp_neg, rsp_ovf, rsp_err
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ft,
    output req1_valid, req1_a, req1_b, req1_ft,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_s, rsp_zero, rsp_neg, rsp_ovf, rsp_err
  );
endinterface

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: two requesters share one signed subtract-and-compare datapath.
// Round-robin grant in IDLE, compute in EXEC, hold result in RESP until the
// consumer takes it (one result per 3 cycles at best).
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : cmp_arbiter_if.slave (two request ports, one response port)
module cmp_arbiter #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  cmp_arbiter_if.slave bus
);
  localparam int NUM_REQ = 2;
  localparam int MSB     = WIDTH - 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       ft;
  } cmp_req_t;

  logic [1:0]               state;
  logic                     last_grant;
  logic                     grant, gnt_any;
  logic [NUM_REQ-1:0]       vld;
  cmp_req_t [NUM_REQ-1:0]   req_in;
  cmp_req_t                 op;
  logic                     op_id;

  logic [WIDTH-1:0]         d;
  logic                     zero, ovf, neg, s, err;

  assign vld       = {bus.req1_valid, bus.req0_valid};
  assign req_in[0] = '{a: bus.req0_a, b: bus.req0_b, ft: bus.req0_ft};
  assign req_in[1] = '{a: bus.req1_a, b: bus.req1_b, ft: bus.req1_ft};

  // On a tie the port that did not win last time goes next.
  always_comb begin
    grant = 1'b0;
    unique case (vld)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

  assign gnt_any        = |vld;
  assign bus.req0_ready = (state == IDLE) & gnt_any & ~grant;
  assign bus.req1_ready = (state == IDLE) & gnt_any &  grant;
  assign bus.rsp_valid  = (state == RESP);

  // Neg is the true signed A<B: the raw sign bit flipped when A-B overflowed.
  always_comb begin
    d    = op.a - op.b;
    zero = (d == '0);
    ovf  = (op.a[MSB] != op.b[MSB]) & (d[MSB] != op.a[MSB]);
    neg  = d[MSB] ^ ovf;
    s    = 1'b1;
    err  = 1'b0;
    unique case (op.ft)
      3'b001:  s = zero;
      3'b000:  s = ~zero;
      3'b010:  s = neg;
      3'b110:  s = neg | zero;
      3'b100:  s = ~neg;
      3'b111:  s = ~neg & ~zero;
      default: begin
        s   = 1'b1;
        err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      op           <= '0;
      op_id        <= 1'b0;
      bus.rsp_id   <= 1'b0;
      bus.rsp_s    <= 1'b0;
      bus.rsp_zero <= 1'b0;
      bus.rsp_neg  <= 1'b0;
      bus.rsp_ovf  <= 1'b0;
      bus.rsp_err  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (gnt_any) begin
          op         <= req_in[grant];
          op_id      <= grant;
          last_grant <= grant;
          state      <= EXEC;
        end
        EXEC: begin
          bus.rsp_id   <= op_id;
          bus.rsp_s    <= s;
          bus.rsp_zero <= zero;
          bus.rsp_neg  <= neg;
          bus.rsp_ovf  <= ovf;
          bus.rsp_err  <= err;
          state        <= RESP;
        end
        RESP: if (bus.rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
